reaction_timer: RTL and testbench

Reaction-time measurement core for the reflex simulator. It consumes the 1 ms enable strobe produced by the clock-divider stage and the raw START and REACT push-buttons. It runs one trial per START press: random fore-period, then the stimulus lamp turns on, then reaction time is measured in milliseconds. It reports either the result, a false start, or a timeout to the display/scoring stage downstream.

---
 rtl/reaction_timer.sv | 139 +++++++++++++
 tb/tb_reaction_timer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction-time measurement core: random fore-period, lamp on, then count ms
// until REACT. Reports result, false start or timeout with a one-cycle strobe.
module reaction_timer #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_W       = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick_1ms,
  input  logic        i_start_n,
  input  logic        i_react_n,
  output logic        o_stimulus,
  output logic        o_busy,
  output logic [13:0] o_result_ms,
  output logic        o_result_valid,
  output logic        o_false_start,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [16:0] MIN_DELAY    = 17'(MIN_DELAY_MS);
  localparam logic [13:0] TIMEOUT_LAST = 14'(TIMEOUT_MS - 1);
  localparam logic [13:0] TIMEOUT_VAL  = 14'(TIMEOUT_MS);

  logic [1:0]  r_startSync;
  logic        r_startPrev;
  logic        r_startEvt;
  logic [1:0]  r_reactSync;
  logic        r_reactPrev;
  logic        r_reactEvt;
  logic [15:0] r_lfsr;
  logic [1:0]  r_state;
  logic [16:0] r_delayCnt;
  logic [13:0] r_rtCnt;
  logic [16:0] w_loadDelay;

  assign w_loadDelay = MIN_DELAY + 17'(r_lfsr[RAND_W-1:0]);

  // Keys idle high, so the synchronizers reset to 1 to avoid a phantom press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_startSync <= 2'b11;
      r_startPrev <= 1'b1;
      r_startEvt  <= 1'b0;
      r_reactSync <= 2'b11;
      r_reactPrev <= 1'b1;
      r_reactEvt  <= 1'b0;
    end else begin
      r_startSync <= {r_startSync[0], i_start_n};
      r_startPrev <= r_startSync[1];
      r_startEvt  <= r_startPrev & ~r_startSync[1];
      r_reactSync <= {r_reactSync[0], i_react_n};
      r_reactPrev <= r_reactSync[1];
      r_reactEvt  <= r_reactPrev & ~r_reactSync[1];
    end
  end

  // Free-running x^16+x^14+x^13+x^11 sequence; sampled only at START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_delayCnt     <= 17'd0;
      r_rtCnt        <= 14'd0;
      o_stimulus     <= 1'b0;
      o_busy         <= 1'b0;
      o_result_ms    <= 14'd0;
      o_result_valid <= 1'b0;
      o_false_start  <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_startEvt) begin
            r_state       <= S_WAIT;
            r_delayCnt    <= w_loadDelay;
            o_busy        <= 1'b1;
            o_false_start <= 1'b0;
            o_timeout     <= 1'b0;
            o_result_ms   <= 14'd0;
          end
        end
        // REACT is tested first so it beats a coincident expiring tick.
        S_WAIT: begin
          if (r_reactEvt) begin
            r_state        <= S_DONE;
            o_busy         <= 1'b0;
            o_false_start  <= 1'b1;
            o_result_ms    <= 14'd0;
            o_result_valid <= 1'b1;
          end else if (i_tick_1ms) begin
            if (r_delayCnt == 17'd1) begin
              r_state    <= S_ARMED;
              r_rtCnt    <= 14'd0;
              o_stimulus <= 1'b1;
            end else begin
              r_delayCnt <= r_delayCnt - 17'd1;
            end
          end
        end
        S_ARMED: begin
          if (r_reactEvt) begin
            r_state        <= S_DONE;
            o_busy         <= 1'b0;
            o_stimulus     <= 1'b0;
            o_result_ms    <= r_rtCnt;
            o_result_valid <= 1'b1;
          end else if (i_tick_1ms) begin
            if (r_rtCnt == TIMEOUT_LAST) begin
              r_state        <= S_DONE;
              o_busy         <= 1'b0;
              o_stimulus     <= 1'b0;
              o_timeout      <= 1'b1;
              o_result_ms    <= TIMEOUT_VAL;
              o_result_valid <= 1'b1;
            end else begin
              r_rtCnt <= r_rtCnt + 14'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with small delays; each task drives one
// scenario and compares outputs against hand-derived values.
module tb_reaction_timer;

  localparam int MIN_DELAY_MS = 4;
  localparam int RAND_W       = 3;
  localparam int TIMEOUT_MS   = 20;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        tick_1ms = 1'b0;
  logic        start_n  = 1'b1;
  logic        react_n  = 1'b1;
  logic        stimulus;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;

  int          assertCount = 0;
  int          failCount   = 0;
  int          tickDiv     = 0;
  int          tickTotal   = 0;
  bit          stimSeen    = 1'b0;
  logic [15:0] lfsrModel;

  reaction_timer #(
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_W      (RAND_W),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick_1ms    (tick_1ms),
    .i_start_n     (start_n),
    .i_react_n     (react_n),
    .o_stimulus    (stimulus),
    .o_busy        (busy),
    .o_result_ms   (result_ms),
    .o_result_valid(result_valid),
    .o_false_start (false_start),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  // 1 ms strobe every 10 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tickDiv  = (tickDiv == 9) ? 0 : tickDiv + 1;
    tick_1ms = (tickDiv == 9);
  end

  always @(posedge clk) begin
    if (tick_1ms) tickTotal <= tickTotal + 1;
    if (stimulus === 1'b1) stimSeen <= 1'b1;
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference sequence used to pick the cycle at which START is captured.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsrModel <= 16'hACE1;
    else        lfsrModel <= lfsrStep(lfsrModel);
  end

  // START pin falls at a negedge; the FSM captures the LFSR 4 edges later,
  // i.e. the value three steps ahead of the one visible now.
  task automatic pressStart(input logic [2:0] val, output bit ok);
    logic [15:0] pred;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pred = lfsrStep(lfsrStep(lfsrStep(lfsrModel)));
      if (pred[2:0] == val) begin
        start_n = 1'b0;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitSignal(input int which, input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cyc = i + 1;
      if ((which == 0 && busy === 1'b1) || (which == 1 && stimulus === 1'b1) ||
          (which == 2 && result_valid === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitTickCount(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (tickTotal >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; start_n = 1'b1; react_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({stimulus, busy, result_valid, false_start, timeout, result_ms} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL reset_values: got %b, expected all zero",
               {stimulus, busy, result_valid, false_start, timeout, result_ms});
    end
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if ({stimulus, busy, result_valid, false_start, timeout, result_ms} !== 19'd0) bad++;
    end
    assertCount++;
    if (bad !== 0) begin
      failCount++;
      $display("[TB] FAIL idle_hold: got %0d nonzero cycles, expected 0", bad);
    end
  endtask

  task automatic test_normal;
    bit ok; int cyc; int busyT; int armT; int pulses;
    pressStart(3'd3, ok);
    waitSignal(0, 10, ok, cyc);
    assertCount++;
    if (!ok || cyc != 4) begin
      failCount++;
      $display("[TB] FAIL start_latency: got ok=%0d cycles=%0d, expected 4 cycles", ok, cyc);
    end
    busyT = tickTotal;
    @(negedge clk) start_n = 1'b1;
    waitSignal(1, 200, ok, cyc);
    assertCount++;
    if (!ok || tickTotal - busyT != 7) begin
      failCount++;
      $display("[TB] FAIL fore_period: got %0d ticks (ok=%0d), expected 7", tickTotal - busyT, ok);
    end
    assertCount++;
    if (tick_1ms !== 1'b1 || busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stim_after_tick: got tick=%b busy=%b, expected 1 1", tick_1ms, busy);
    end
    armT = tickTotal;
    waitTickCount(armT + 5, 100, ok);
    @(negedge clk) react_n = 1'b0;
    waitSignal(2, 20, ok, cyc);
    assertCount++;
    if (!ok || result_ms !== 14'd5) begin
      failCount++;
      $display("[TB] FAIL result_normal: got %0d (ok=%0d), expected 5", result_ms, ok);
    end
    assertCount++;
    if ({stimulus, busy, false_start, timeout} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL flags_normal: got %b, expected 0000", {stimulus, busy, false_start, timeout});
    end
    @(negedge clk) react_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) pulses++;
    end
    assertCount++;
    if (pulses != 0 || result_ms !== 14'd5) begin
      failCount++;
      $display("[TB] FAIL valid_pulse_hold: got %0d extra pulses result=%0d, expected 0 and 5", pulses, result_ms);
    end
  endtask

  task automatic test_false_start_timeout;
    bit ok; int cyc; int busyT; int armT;
    stimSeen = 1'b0;
    pressStart(3'd0, ok);
    waitSignal(0, 10, ok, cyc);
    assertCount++;
    if (!ok || result_ms !== 14'd0) begin
      failCount++;
      $display("[TB] FAIL result_clear: got %0d (ok=%0d), expected 0", result_ms, ok);
    end
    busyT = tickTotal;
    @(negedge clk) start_n = 1'b1;
    waitTickCount(busyT + 2, 100, ok);
    @(negedge clk) react_n = 1'b0;
    waitSignal(2, 20, ok, cyc);
    assertCount++;
    if (!ok || {false_start, timeout, result_ms} !== {1'b1, 1'b0, 14'd0}) begin
      failCount++;
      $display("[TB] FAIL false_start: got fs=%b to=%b res=%0d, expected 1 0 0", false_start, timeout, result_ms);
    end
    @(negedge clk) react_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    assertCount++;
    if (stimSeen !== 1'b0 || false_start !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stim_never_rose: got seen=%b fs=%b, expected 0 1", stimSeen, false_start);
    end
    pressStart(3'd1, ok);
    waitSignal(0, 10, ok, cyc);
    assertCount++;
    if (!ok || false_start !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL false_start_clear: got %b (ok=%0d), expected 0", false_start, ok);
    end
    busyT = tickTotal;
    @(negedge clk) start_n = 1'b1;
    waitSignal(1, 200, ok, cyc);
    armT = tickTotal;
    assertCount++;
    if (!ok || armT - busyT != 5) begin
      failCount++;
      $display("[TB] FAIL fore_period_5: got %0d ticks (ok=%0d), expected 5", armT - busyT, ok);
    end
    waitSignal(2, 400, ok, cyc);
    assertCount++;
    if (!ok || tickTotal - armT != 20 || result_ms !== 14'd20) begin
      failCount++;
      $display("[TB] FAIL timeout_result: got ticks=%0d res=%0d (ok=%0d), expected 20 20", tickTotal - armT, result_ms, ok);
    end
    assertCount++;
    if ({timeout, stimulus, busy, false_start} !== 4'b1000) begin
      failCount++;
      $display("[TB] FAIL timeout_flags: got %b, expected 1000", {timeout, stimulus, busy, false_start});
    end
  endtask

  task automatic test_simultaneous;
    bit ok; int cyc; int busyT; int armT;
    pressStart(3'd2, ok);
    waitSignal(0, 10, ok, cyc);
    @(negedge clk) start_n = 1'b1;
    waitSignal(1, 200, ok, cyc);
    armT = tickTotal;
    waitTickCount(armT + 19, 400, ok);
    repeat (6) @(posedge clk);
    @(negedge clk) react_n = 1'b0;
    waitSignal(2, 20, ok, cyc);
    assertCount++;
    if (!ok || tickTotal - armT != 20 || result_ms !== 14'd19 || timeout !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL react_vs_timeout: got ticks=%0d res=%0d to=%b, expected 20 19 0", tickTotal - armT, result_ms, timeout);
    end
    @(negedge clk) react_n = 1'b1;
    repeat (5) @(posedge clk);
    pressStart(3'd0, ok);
    waitSignal(0, 10, ok, cyc);
    busyT = tickTotal;
    stimSeen = 1'b0;
    @(negedge clk) start_n = 1'b1;
    waitTickCount(busyT + 3, 100, ok);
    repeat (6) @(posedge clk);
    @(negedge clk) react_n = 1'b0;
    waitSignal(2, 20, ok, cyc);
    assertCount++;
    if (!ok || tickTotal - busyT != 4 || false_start !== 1'b1 || stimSeen !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL react_vs_expiry: got ticks=%0d fs=%b seen=%b, expected 4 1 0", tickTotal - busyT, false_start, stimSeen);
    end
    @(negedge clk) react_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok; int cyc; int busyT;
    pressStart(3'd3, ok);
    waitSignal(0, 10, ok, cyc);
    @(negedge clk) start_n = 1'b1;
    waitSignal(1, 200, ok, cyc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    assertCount++;
    if (!ok || {stimulus, busy, result_valid} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL async_reset: got %b (ok=%0d), expected 000", {stimulus, busy, result_valid}, ok);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pressStart(3'd3, ok);
    waitSignal(0, 10, ok, cyc);
    assertCount++;
    if (!ok || cyc != 4) begin
      failCount++;
      $display("[TB] FAIL fresh_trial: got ok=%0d cycles=%0d, expected 4 cycles", ok, cyc);
    end
    busyT = tickTotal;
    @(negedge clk) start_n = 1'b1;
    waitTickCount(busyT + 2, 100, ok);
    pressStart(3'd7, ok);
    waitSignal(1, 300, ok, cyc);
    assertCount++;
    if (!ok || tickTotal - busyT != 7) begin
      failCount++;
      $display("[TB] FAIL no_reload: got %0d ticks (ok=%0d), expected 7", tickTotal - busyT, ok);
    end
    @(negedge clk) start_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish by 300000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reaction_timer bench starting");
    test_reset();
    test_normal();
    test_false_start_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
